// File: rtl/a2d_seq.sv
// A2D conversion sequencer: channel-select frame, GAP_CYC idle cycles, then read frame(s) via the SPI master.
// Define A2D_AVG_EN to average four read frames per conversion.
module a2d_seq #(
    parameter int unsigned GAP_CYC = 2,
    parameter logic [10:0] CMD_PAD = 11'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    output logic        cnv_cmplt,
    output logic [11:0] res,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data
);

    typedef enum logic [1:0] {IDLE, CMD, GAP, READ} state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

    state_t      state_q, state_d;
    logic        wrt_q, wrt_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cnv_cmplt_q, cnv_cmplt_d;
    logic [11:0] res_q, res_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [2:0]  chnl_lat_q, chnl_lat_d;
`ifdef A2D_AVG_EN
    logic [13:0] acc_q, acc_d;
    logic [1:0]  frm_cnt_q, frm_cnt_d;
`endif

    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_data[15:12];

    always_comb begin
        state_d     = state_q;
        wrt_d       = 1'b0;
        cmd_d       = cmd_q;
        cnv_cmplt_d = cnv_cmplt_q;
        res_d       = res_q;
        gap_cnt_d   = gap_cnt_q;
        chnl_lat_d  = chnl_lat_q;
`ifdef A2D_AVG_EN
        acc_d       = acc_q;
        frm_cnt_d   = frm_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (strt_cnv) begin
                    chnl_lat_d  = chnnl;
                    cmd_d       = {2'b00, chnl_lat_d, CMD_PAD};
                    wrt_d       = 1'b1;
                    cnv_cmplt_d = 1'b0;
                    state_d     = CMD;
`ifdef A2D_AVG_EN
                    acc_d       = '0;
                    frm_cnt_d   = '0;
`endif
                end
            end
            // done is still stale from the previous frame during the wrt cycle
            CMD: begin
                if (!wrt_q && done) begin
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    wrt_d   = 1'b1;
                    state_d = READ;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            READ: begin
                if (!wrt_q && done) begin
`ifdef A2D_AVG_EN
                    acc_d = acc_q + {2'b00, rd_data[11:0]};
                    if (frm_cnt_q == 2'd3) begin
                        res_d       = acc_d[13:2];
                        cnv_cmplt_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        frm_cnt_d = frm_cnt_q + 2'd1;
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end
`else
                    res_d       = rd_data[11:0];
                    cnv_cmplt_d = 1'b1;
                    state_d     = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wrt_q       <= 1'b0;
            cmd_q       <= '0;
            cnv_cmplt_q <= 1'b0;
            res_q       <= '0;
            gap_cnt_q   <= '0;
            chnl_lat_q  <= '0;
`ifdef A2D_AVG_EN
            acc_q       <= '0;
            frm_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wrt_q       <= wrt_d;
            cmd_q       <= cmd_d;
            cnv_cmplt_q <= cnv_cmplt_d;
            res_q       <= res_d;
            gap_cnt_q   <= gap_cnt_d;
            chnl_lat_q  <= chnl_lat_d;
`ifdef A2D_AVG_EN
            acc_q       <= acc_d;
            frm_cnt_q   <= frm_cnt_d;
`endif
        end
    end

    assign wrt       = wrt_q;
    assign cmd       = cmd_q;
    assign cnv_cmplt = cnv_cmplt_q;
    assign res       = res_q;

endmodule

// File: tb/tb_a2d_seq.sv
// Scoreboard bench for a2d_seq: SPI master model, cmd/res queues filled at request time.
module tb_a2d_seq;

    localparam int unsigned GAP = 2;
    localparam logic [10:0] PAD = 11'h000;
`ifdef A2D_AVG_EN
    localparam int NREAD = 4;
`else
    localparam int NREAD = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;

    a2d_seq #(.GAP_CYC(GAP), .CMD_PAD(PAD)) dut (
        .clk(clk), .rst_n(rst_n), .strt_cnv(strt_cnv), .chnnl(chnnl),
        .cnv_cmplt(cnv_cmplt), .res(res), .wrt(wrt), .cmd(cmd),
        .done(done), .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int frames_done = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        bit          first;
    } frame_t;

    frame_t      frame_q[$];
    logic [15:0] cmd_q[$];
    logic [11:0] exp_q[$];
    logic [11:0] res_model = '0;
    logic [15:0] rdw[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SPI master model: done drops on the edge after wrt, rises after a random frame time
    initial begin : master
        int     cnt;
        int     last_done;
        int     wcyc;
        bit     w;
        frame_t cur;
        cnt = 0;
        last_done = 0;
        cur = '{data: 16'h0, first: 1'b1};
        done = 1'b0;
        rd_data = '0;
        forever begin
            @(negedge clk);
            w = (wrt === 1'b1);
            wcyc = cyc;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                cnt = 0;
                done = 1'b0;
            end else if (w) begin
                check("wrt_while_busy", cnt, 0);
                if (frame_q.size() > 0) cur = frame_q.pop_front();
                else cur = '{data: 16'($urandom), first: 1'b1};
                if (!cur.first) check("gap_cycles", wcyc - last_done, GAP + 1);
                done = 1'b0;
                cnt = $urandom_range(6, 1);
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    done = 1'b1;
                    rd_data = cur.data;
                    last_done = cyc;
                    frames_done++;
                end
            end
        end
    end

    initial begin : wrt_mon
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (wrt === 1'b1) begin
                check("wrt_back_to_back", prev, 0);
                if (cmd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wrt: wrt=1 cmd=%h with no frame expected", cmd);
                end else begin
                    check("cmd", cmd, cmd_q.pop_front());
                end
            end
            prev = wrt;
        end
    end

    initial begin : cmplt_mon
        logic       prev;
        logic [11:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (cnv_cmplt === 1'b1 && prev !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmplt: res=%h with no conversion pending", res);
                end else begin
                    e = exp_q.pop_front();
                    check("res", res, e);
                    res_model = e;
                end
            end
            prev = cnv_cmplt;
        end
    end

    // Expected result is the low 12 bits of the read frame, or the truncated mean of four
    task automatic issue(input logic [2:0] ch);
        int sum;
        logic [11:0] e;
        sum = 0;
        frame_q.push_back('{data: 16'($urandom), first: 1'b1});
        for (int i = 0; i < NREAD; i++) begin
            frame_q.push_back('{data: rdw[i], first: 1'b0});
            sum += int'(rdw[i][11:0]);
        end
        e = 12'(sum / NREAD);
        exp_q.push_back(e);
        for (int i = 0; i <= NREAD; i++)
            cmd_q.push_back(16'((int'(ch) << 11) | int'(PAD)));
        chnnl = ch;
        strt_cnv = 1'b1;
        @(negedge clk);
        strt_cnv = 1'b0;
        chnnl = 3'($urandom);
        check("cmplt_clr", cnv_cmplt, 0);
        check("res_hold", res, res_model);
    endtask

    task automatic wait_cmplt(input bit noise);
        int n;
        for (n = 0; n < 2000; n++) begin
            @(negedge clk);
            strt_cnv = 1'b0;
            if (cnv_cmplt === 1'b1) break;
            if (noise && $urandom_range(3, 0) == 0) begin
                strt_cnv = 1'b1;
                chnnl = 3'($urandom);
            end
        end
        if (n == 2000) begin
            checks++;
            errors++;
            $display("FAIL cmplt_timeout: cnv_cmplt=%b after %0d cycles, required 1", cnv_cmplt, n);
        end
    endtask

    initial begin : stim
        int f0;
        int k;
        rst_n = 1'b0;
        strt_cnv = 1'b0;
        chnnl = '0;
        repeat (3) @(negedge clk);
        check("rst_wrt", wrt, 0);
        check("rst_cmd", cmd, 16'h0000);
        check("rst_res", res, 12'h000);
        check("rst_cmplt", cnv_cmplt, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // channel 5 with ignored requests on channel 1 while busy
        rdw = '{16'hFABC, 16'hFABC, 16'hFABC, 16'hFABC};
        issue(3'd5);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            strt_cnv = 1'b0;
            if (cnv_cmplt === 1'b1) break;
            if ($urandom_range(2, 0) == 0) begin
                strt_cnv = 1'b1;
                chnnl = 3'd1;
            end
        end
        check("first_res", res, 12'hABC);

        // back-to-back request in the cycle completion is visible
        for (int i = 0; i < 4; i++) rdw[i] = 16'($urandom);
        issue(3'd7);
        wait_cmplt(1'b1);

        // idle with done left high: nothing moves
        repeat (12) @(negedge clk);
        check("idle_cmplt_hold", cnv_cmplt, 1);
        check("idle_res_hold", res, res_model);

`ifdef A2D_AVG_EN
        rdw = '{16'h3100, 16'hC101, 16'h0102, 16'h7104};
        issue(3'($urandom));
        wait_cmplt(1'b0);
        check("avg_res", res, 12'h101);
`endif

        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < 4; i++) rdw[i] = 16'($urandom);
            if ($urandom_range(1, 0) == 1) repeat ($urandom_range(5, 1)) @(negedge clk);
            issue(3'($urandom));
            wait_cmplt(1'($urandom));
        end

        // reset while in GAP
        for (int i = 0; i < 4; i++) rdw[i] = 16'($urandom);
        f0 = frames_done;
        issue(3'd2);
        for (k = 0; k < 100; k++) begin
            if (frames_done != f0) break;
            @(negedge clk);
        end
        if (k == 100) begin
            checks++;
            errors++;
            $display("FAIL first_frame_timeout: frames_done=%0d required %0d", frames_done, f0 + 1);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_wrt", wrt, 0);
        check("midrst_cmd", cmd, 16'h0000);
        check("midrst_res", res, 12'h000);
        check("midrst_cmplt", cnv_cmplt, 0);
        frame_q.delete();
        cmd_q.delete();
        exp_q.delete();
        res_model = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("post_rst_cmplt", cnv_cmplt, 0);
        check("post_rst_res", res, 12'h000);

        for (int i = 0; i < 4; i++) rdw[i] = 16'($urandom);
        issue(3'($urandom));
        wait_cmplt(1'b0);

        repeat (5) @(negedge clk);
        check("queues_drained", 32'(cmd_q.size() + exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/a2d_seq.md
Name: a2d_seq

Overview:
- Conversion sequencer that sits directly upstream of the 16-bit SPI master.
- Accepts a conversion request for one of 8 A2D channels and drives the master's wrt/cmd/done handshake.
- Runs two SPI transactions per conversion: a channel-select command, then a read frame.
- Captures the 12-bit result and flags completion to the consumer.

Parameters:
GAP_CYC, 2, idle clk cycles between done of transaction 1 and wrt of transaction 2 (1..15)
CMD_PAD, 11'h000, low 11 bits appended to channel in command word

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
strt_cnv  input  1  one-cycle request to start a conversion
chnnl  input  3  channel to convert, sampled when strt_cnv is accepted
cnv_cmplt  output  1  conversion complete flag
res  output  12  conversion result
wrt  output  1  one-cycle start pulse to SPI master
cmd  output  16  command word to SPI master
done  input  1  SPI master transaction done (level; cleared by master the cycle after wrt)
rd_data  input  16  SPI master received frame

Behaviour:
- Clock: one clock, clk. Reset: rst_n, asynchronous, active-low.
- Reset values: state IDLE, wrt 0, cmd 16'h0000, cnv_cmplt 0, res 12'h000, gap counter 0, latched channel 0.
- Reset mid-operation aborts immediately to IDLE with reset values. Any SPI frame in flight is abandoned.
- Command word: {2'b00, chnl_lat, CMD_PAD}. It is registered and stays stable from the wrt cycle until the next wrt.
- States:
  - IDLE: on strt_cnv, latch chnnl, assert wrt for one cycle with cmd loaded, clear cnv_cmplt, go to CMD.
  - CMD: wait for done=1. The master clears done on the edge after wrt, so done is not sampled in the wrt cycle itself. On done, clear gap counter and go to GAP.
  - GAP: count GAP_CYC cycles. On terminal count, pulse wrt (cmd unchanged) and go to READ.
  - READ: wait for done=1. On done, res <= rd_data[11:0], cnv_cmplt <= 1, go to IDLE.
- Latency: strt_cnv to cnv_cmplt = 1 + T1 + GAP_CYC + 1 + T2 cycles, where T1 and T2 are the master frame times.
- cnv_cmplt is a set/reset flop:
  - Set with res in the same edge.
  - Held until the next accepted strt_cnv.
  - In IDLE, strt_cnv has priority: a strt_cnv in the cycle after completion clears it.
- res holds its last value until the next completion. It is never updated from the first frame.
- strt_cnv while not in IDLE is ignored; chnnl is not re-sampled.
- wrt is never asserted for two consecutive cycles. wrt is never asserted while waiting on done.
- done high in IDLE (left over from a previous frame) is ignored.
- Unused encodings of the state register go to IDLE.

Optional Feature:
- Macro: A2D_AVG_EN
- Defined:
  - READ completion does not finish the conversion. The sequencer accumulates rd_data[11:0] into a 14-bit sum and repeats GAP→READ until 4 read frames are captured.
  - Only one CMD frame is issued per conversion.
  - res <= sum[13:2] (truncating), then cnv_cmplt sets.
  - The accumulator and frame counter clear on accepted strt_cnv and on reset.
- Undefined: single read frame as above; no accumulator or frame-counter logic is synthesized.

Test Plan:
- Reset then strt_cnv with chnnl=3'd5 → first wrt with cmd=16'h2800; after done, exactly GAP_CYC=2 idle cycles, then second wrt with cmd=16'h2800. Master model returns 16'hFABC → res=12'hABC, cnv_cmplt=1.
- strt_cnv pulsed again during CMD and READ with chnnl=3'd1 → ignored: no extra wrt, cmd keeps channel 5, single completion.
- Back-to-back: strt_cnv with chnnl=3'd7 one cycle after cnv_cmplt rises → cnv_cmplt clears next edge, cmd=16'h3800, res holds 12'hABC until new done.
- Assert rst_n=0 mid-GAP → wrt=0, cmd=0, res=0, cnv_cmplt=0 immediately; no second wrt after release.
- Stale done: master done held at 1 in IDLE → no state change until strt_cnv; wrt never high on consecutive cycles.
- With A2D_AVG_EN, reads 12'h100, 12'h101, 12'h102, 12'h104 → one CMD frame, four read frames, res=12'h101.
